// File: rtl/n101_icb_rr_arbt_if.sv
// One ICB channel: command and response handshakes with their payloads.
// The master modport issues commands; the slave modport accepts them and returns responses.
interface n101_icb_rr_arbt_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [AW-1:0]     icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [DW/8-1:0]   icb_cmd_wmask;
    logic              icb_cmd_lock;

    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic              icb_rsp_err;
    logic [DW-1:0]     icb_rsp_rdata;

    modport master (
        output icb_cmd_valid,
        input  icb_cmd_ready,
        output icb_cmd_addr,
        output icb_cmd_read,
        output icb_cmd_wdata,
        output icb_cmd_wmask,
        output icb_cmd_lock,
        input  icb_rsp_valid,
        output icb_rsp_ready,
        input  icb_rsp_err,
        input  icb_rsp_rdata
    );

    modport slave (
        input  icb_cmd_valid,
        output icb_cmd_ready,
        input  icb_cmd_addr,
        input  icb_cmd_read,
        input  icb_cmd_wdata,
        input  icb_cmd_wmask,
        input  icb_cmd_lock,
        output icb_rsp_valid,
        input  icb_rsp_ready,
        output icb_rsp_err,
        output icb_rsp_rdata
    );
endinterface

// File: rtl/n101_icb_rr_arbt.sv
// Two-requester ICB round-robin arbiter with bus-lock support and in-order response routing.
// Commands and responses pass through combinationally; an id FIFO remembers who owns each response.
module n101_icb_rr_arbt #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned OUTS_NUM = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    n101_icb_rr_arbt_if.slave  i0_icb,
    n101_icb_rr_arbt_if.slave  i1_icb,
    n101_icb_rr_arbt_if.master o_icb,
    output logic               arbt_active
);
    localparam int unsigned CW = $clog2(OUTS_NUM + 1);
    localparam int unsigned PW = (OUTS_NUM > 1) ? $clog2(OUTS_NUM) : 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTS_NUM);
    localparam logic [PW-1:0] LAST_IDX = PW'(OUTS_NUM - 1);

    logic                r_ptr;
    logic                r_lock_own;
    logic                r_lock_id;
    logic [OUTS_NUM-1:0] r_fifo;
    logic [CW-1:0]       r_cnt;
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;

    logic w_full;
    logic w_empty;
    logic w_any_valid;
    logic w_sel;
    logic w_sel_valid;
    logic w_sel_lock;
    logic w_cmd_hs;
    logic w_rsp_hs;
    logic w_head;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PW'(1);
    endfunction

    assign w_full      = (r_cnt == FULL_CNT);
    assign w_empty     = (r_cnt == '0);
    assign w_any_valid = i0_icb.icb_cmd_valid | i1_icb.icb_cmd_valid;
    assign w_head      = r_fifo[r_rd_ptr];

    // A held lock pins the grant even when the owner is idle, so the other side starves.
    always_comb begin
        w_sel = r_ptr;
        if (r_lock_own) begin
            w_sel = r_lock_id;
        end else if (i0_icb.icb_cmd_valid && !i1_icb.icb_cmd_valid) begin
            w_sel = 1'b0;
        end else if (i1_icb.icb_cmd_valid && !i0_icb.icb_cmd_valid) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_valid = w_sel ? i1_icb.icb_cmd_valid : i0_icb.icb_cmd_valid;
    assign w_sel_lock  = w_sel ? i1_icb.icb_cmd_lock  : i0_icb.icb_cmd_lock;

    always_comb begin
        o_icb.icb_cmd_addr  = '0;
        o_icb.icb_cmd_read  = 1'b0;
        o_icb.icb_cmd_wdata = '0;
        o_icb.icb_cmd_wmask = '0;
        o_icb.icb_cmd_lock  = 1'b0;
        if (w_any_valid) begin
            if (w_sel) begin
                o_icb.icb_cmd_addr  = i1_icb.icb_cmd_addr;
                o_icb.icb_cmd_read  = i1_icb.icb_cmd_read;
                o_icb.icb_cmd_wdata = i1_icb.icb_cmd_wdata;
                o_icb.icb_cmd_wmask = i1_icb.icb_cmd_wmask;
                o_icb.icb_cmd_lock  = i1_icb.icb_cmd_lock;
            end else begin
                o_icb.icb_cmd_addr  = i0_icb.icb_cmd_addr;
                o_icb.icb_cmd_read  = i0_icb.icb_cmd_read;
                o_icb.icb_cmd_wdata = i0_icb.icb_cmd_wdata;
                o_icb.icb_cmd_wmask = i0_icb.icb_cmd_wmask;
                o_icb.icb_cmd_lock  = i0_icb.icb_cmd_lock;
            end
        end
    end

    assign o_icb.icb_cmd_valid  = w_sel_valid & ~w_full;
    assign i0_icb.icb_cmd_ready = ~w_sel & o_icb.icb_cmd_ready & ~w_full;
    assign i1_icb.icb_cmd_ready =  w_sel & o_icb.icb_cmd_ready & ~w_full;
    assign w_cmd_hs             = o_icb.icb_cmd_valid & o_icb.icb_cmd_ready;

    // Unsolicited responses (nothing outstanding) are held off rather than routed.
    assign i0_icb.icb_rsp_valid = o_icb.icb_rsp_valid & ~w_empty & ~w_head;
    assign i1_icb.icb_rsp_valid = o_icb.icb_rsp_valid & ~w_empty &  w_head;
    assign i0_icb.icb_rsp_err   = o_icb.icb_rsp_err;
    assign i1_icb.icb_rsp_err   = o_icb.icb_rsp_err;
    assign i0_icb.icb_rsp_rdata = o_icb.icb_rsp_rdata;
    assign i1_icb.icb_rsp_rdata = o_icb.icb_rsp_rdata;
    assign o_icb.icb_rsp_ready  = ~w_empty &
                                  (w_head ? i1_icb.icb_rsp_ready : i0_icb.icb_rsp_ready);
    assign w_rsp_hs             = o_icb.icb_rsp_valid & o_icb.icb_rsp_ready;

    assign arbt_active = w_any_valid | ~w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= 1'b0;
            r_lock_own <= 1'b0;
            r_lock_id  <= 1'b0;
        end else if (w_cmd_hs) begin
            r_ptr <= ~w_sel;
            if (w_sel_lock) begin
                r_lock_own <= 1'b1;
                r_lock_id  <= w_sel;
            end else if (r_lock_own && (w_sel == r_lock_id)) begin
                r_lock_own <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_cmd_hs) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= f_inc(r_wr_ptr);
            end
            if (w_rsp_hs) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            unique case ({w_cmd_hs, w_rsp_hs})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_n101_icb_rr_arbt.sv
// Randomized and directed bench for n101_icb_rr_arbt against a queue-based arbitration model.
module tb_n101_icb_rr_arbt;
    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned OUTS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic arbt_active;

    n101_icb_rr_arbt_if #(.AW(AW), .DW(DW)) i0_icb ();
    n101_icb_rr_arbt_if #(.AW(AW), .DW(DW)) i1_icb ();
    n101_icb_rr_arbt_if #(.AW(AW), .DW(DW)) o_icb ();

    n101_icb_rr_arbt #(.AW(AW), .DW(DW), .OUTS_NUM(OUTS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i0_icb      (i0_icb),
        .i1_icb      (i1_icb),
        .o_icb       (o_icb),
        .arbt_active (arbt_active)
    );

    always #10 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // Model: ids of outstanding commands in issue order, plus fairness and lock bookkeeping.
    bit m_q[$];
    bit m_ptr, m_lock_own, m_lock_id;
    bit dut_grants[$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ptr      = 1'b0;
        m_lock_own = 1'b0;
        m_lock_id  = 1'b0;
    endtask

    task automatic compare_cycle();
        bit v0, v1, any, full, empty, sel, exp_ov, head, exp_rr;
        if (!rst_n) model_reset();
        v0    = i0_icb.icb_cmd_valid;
        v1    = i1_icb.icb_cmd_valid;
        any   = v0 | v1;
        full  = (m_q.size() == OUTS);
        empty = (m_q.size() == 0);
        if (m_lock_own)    sel = m_lock_id;
        else if (v0 && !v1) sel = 1'b0;
        else if (v1 && !v0) sel = 1'b1;
        else               sel = m_ptr;
        exp_ov = (sel ? v1 : v0) && !full;
        check("o_cmd_valid", o_icb.icb_cmd_valid, exp_ov);
        if (exp_ov) begin
            check("o_cmd_addr",  o_icb.icb_cmd_addr,  sel ? i1_icb.icb_cmd_addr  : i0_icb.icb_cmd_addr);
            check("o_cmd_read",  o_icb.icb_cmd_read,  sel ? i1_icb.icb_cmd_read  : i0_icb.icb_cmd_read);
            check("o_cmd_wdata", o_icb.icb_cmd_wdata, sel ? i1_icb.icb_cmd_wdata : i0_icb.icb_cmd_wdata);
            check("o_cmd_wmask", o_icb.icb_cmd_wmask, sel ? i1_icb.icb_cmd_wmask : i0_icb.icb_cmd_wmask);
            check("o_cmd_lock",  o_icb.icb_cmd_lock,  sel ? i1_icb.icb_cmd_lock  : i0_icb.icb_cmd_lock);
        end
        if (!any) begin
            check("idle_addr_zero",  o_icb.icb_cmd_addr, 0);
            check("idle_wdata_zero", o_icb.icb_cmd_wdata, 0);
        end else begin
            check("i0_cmd_ready", i0_icb.icb_cmd_ready, !sel && o_icb.icb_cmd_ready && !full);
            check("i1_cmd_ready", i1_icb.icb_cmd_ready,  sel && o_icb.icb_cmd_ready && !full);
        end
        head   = empty ? 1'b0 : m_q[0];
        exp_rr = !empty && (head ? i1_icb.icb_rsp_ready : i0_icb.icb_rsp_ready);
        check("i0_rsp_valid", i0_icb.icb_rsp_valid, o_icb.icb_rsp_valid && !empty && !head);
        check("i1_rsp_valid", i1_icb.icb_rsp_valid, o_icb.icb_rsp_valid && !empty && head);
        check("o_rsp_ready", o_icb.icb_rsp_ready, exp_rr);
        if (o_icb.icb_rsp_valid && !empty) begin
            check("rsp_rdata", head ? i1_icb.icb_rsp_rdata : i0_icb.icb_rsp_rdata,
                  o_icb.icb_rsp_rdata);
            check("rsp_err", head ? i1_icb.icb_rsp_err : i0_icb.icb_rsp_err, o_icb.icb_rsp_err);
        end
        check("arbt_active", arbt_active, any || !empty);
        if (rst_n) begin
            if (i0_icb.icb_cmd_valid && i0_icb.icb_cmd_ready) dut_grants.push_back(1'b0);
            else if (i1_icb.icb_cmd_valid && i1_icb.icb_cmd_ready) dut_grants.push_back(1'b1);
            if (exp_rr && o_icb.icb_rsp_valid) void'(m_q.pop_front());
            if (exp_ov && o_icb.icb_cmd_ready) begin
                m_q.push_back(sel);
                m_ptr = !sel;
                if (sel ? i1_icb.icb_cmd_lock : i0_icb.icb_cmd_lock) begin
                    m_lock_own = 1'b1;
                    m_lock_id  = sel;
                end else if (m_lock_own && sel == m_lock_id) begin
                    m_lock_own = 1'b0;
                end
            end
        end
    endtask

    // Inputs change just after posedge; outputs are compared on the falling edge.
    task automatic cycle();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        i0_icb.icb_cmd_valid = 0; i0_icb.icb_cmd_addr = 0; i0_icb.icb_cmd_read = 0;
        i0_icb.icb_cmd_wdata = 0; i0_icb.icb_cmd_wmask = 0; i0_icb.icb_cmd_lock = 0;
        i0_icb.icb_rsp_ready = 0;
        i1_icb.icb_cmd_valid = 0; i1_icb.icb_cmd_addr = 0; i1_icb.icb_cmd_read = 0;
        i1_icb.icb_cmd_wdata = 0; i1_icb.icb_cmd_wmask = 0; i1_icb.icb_cmd_lock = 0;
        i1_icb.icb_rsp_ready = 0;
        o_icb.icb_cmd_ready = 0; o_icb.icb_rsp_valid = 0; o_icb.icb_rsp_err = 0;
        o_icb.icb_rsp_rdata = 0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic randomize_inputs();
        i0_icb.icb_cmd_valid = ($urandom_range(0, 99) < 60);
        i0_icb.icb_cmd_addr  = $urandom;
        i0_icb.icb_cmd_read  = 1'($urandom);
        i0_icb.icb_cmd_wdata = $urandom;
        i0_icb.icb_cmd_wmask = 4'($urandom);
        i0_icb.icb_cmd_lock  = ($urandom_range(0, 3) == 0);
        i0_icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
        i1_icb.icb_cmd_valid = ($urandom_range(0, 99) < 60);
        i1_icb.icb_cmd_addr  = $urandom;
        i1_icb.icb_cmd_read  = 1'($urandom);
        i1_icb.icb_cmd_wdata = $urandom;
        i1_icb.icb_cmd_wmask = 4'($urandom);
        i1_icb.icb_cmd_lock  = ($urandom_range(0, 3) == 0);
        i1_icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
        o_icb.icb_cmd_ready  = ($urandom_range(0, 3) != 0);
        o_icb.icb_rsp_valid  = ($urandom_range(0, 1) == 0);
        o_icb.icb_rsp_err    = 1'($urandom);
        o_icb.icb_rsp_rdata  = $urandom;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Both requesters always valid, one response per cycle: grants alternate from i0.
        i0_icb.icb_cmd_valid = 1; i1_icb.icb_cmd_valid = 1;
        o_icb.icb_cmd_ready = 1; i0_icb.icb_rsp_ready = 1; i1_icb.icb_rsp_ready = 1;
        dut_grants.delete();
        for (int k = 0; k < 6; k++) begin
            o_icb.icb_rsp_valid = (k > 0);
            o_icb.icb_rsp_rdata = 32'hA000 + k;
            #1;
            if (k > 0) begin
                check("alt_rsp_route", (k % 2 == 1) ? i0_icb.icb_rsp_valid : i1_icb.icb_rsp_valid, 1);
            end
            cycle();
        end
        check("alt_grant_count", dut_grants.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < dut_grants.size()) check("alt_grant", dut_grants[k], k % 2);
        end

        // Full blocks the third command, even while a pop happens in that cycle.
        do_reset();
        i0_icb.icb_cmd_valid = 1; o_icb.icb_cmd_ready = 1; i0_icb.icb_rsp_ready = 1;
        cycle();
        cycle();
        #1;
        check("full_o_valid", o_icb.icb_cmd_valid, 0);
        check("full_i0_ready", i0_icb.icb_cmd_ready, 0);
        check("full_i1_ready", i1_icb.icb_cmd_ready, 0);
        o_icb.icb_rsp_valid = 1;
        #1;
        check("full_pop_o_valid", o_icb.icb_cmd_valid, 0);
        check("full_pop_rsp_ready", o_icb.icb_rsp_ready, 1);
        cycle();
        o_icb.icb_rsp_valid = 0;
        #1;
        check("after_pop_o_valid", o_icb.icb_cmd_valid, 1);
        check("after_pop_i0_ready", i0_icb.icb_cmd_ready, 1);
        cycle();

        // Lock sequence from i0 with i1 always pending.
        do_reset();
        i1_icb.icb_cmd_valid = 1; o_icb.icb_cmd_ready = 1;
        o_icb.icb_rsp_valid = 1; i0_icb.icb_rsp_ready = 1; i1_icb.icb_rsp_ready = 1;
        i0_icb.icb_cmd_valid = 1; i0_icb.icb_cmd_lock = 1;
        #1; check("lock_a_i0_ready", i0_icb.icb_cmd_ready, 1);
        cycle();
        i0_icb.icb_cmd_valid = 0;
        #1;
        check("lock_idle_i1_ready", i1_icb.icb_cmd_ready, 0);
        check("lock_idle_o_valid", o_icb.icb_cmd_valid, 0);
        cycle();
        i0_icb.icb_cmd_valid = 1;
        #1; check("lock_b_i0_ready", i0_icb.icb_cmd_ready, 1);
        cycle();
        i0_icb.icb_cmd_lock = 0;
        #1;
        check("lock_c_i0_ready", i0_icb.icb_cmd_ready, 1);
        check("lock_c_i1_ready", i1_icb.icb_cmd_ready, 0);
        cycle();
        #1; check("unlock_i1_ready", i1_icb.icb_cmd_ready, 1);
        cycle();

        // Unsolicited response with nothing outstanding.
        do_reset();
        o_icb.icb_rsp_valid = 1; i0_icb.icb_rsp_ready = 1; i1_icb.icb_rsp_ready = 1;
        #1;
        check("unsol_rsp_ready", o_icb.icb_rsp_ready, 0);
        check("unsol_i0_valid", i0_icb.icb_rsp_valid, 0);
        check("unsol_i1_valid", i1_icb.icb_rsp_valid, 0);
        cycle();
        check("unsol_active", arbt_active, 0);

        // Stalled response to i1 for three cycles, then delivered.
        do_reset();
        i1_icb.icb_cmd_valid = 1; o_icb.icb_cmd_ready = 1;
        cycle();
        i1_icb.icb_cmd_valid = 0;
        o_icb.icb_rsp_valid = 1; o_icb.icb_rsp_rdata = 32'hCAFE_F00D; o_icb.icb_rsp_err = 1;
        i0_icb.icb_rsp_ready = 1; i1_icb.icb_rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("stall_rsp_ready", o_icb.icb_rsp_ready, 0);
            check("stall_i1_valid", i1_icb.icb_rsp_valid, 1);
            check("stall_i0_valid", i0_icb.icb_rsp_valid, 0);
            cycle();
        end
        i1_icb.icb_rsp_ready = 1;
        #1;
        check("stall_release_ready", o_icb.icb_rsp_ready, 1);
        check("stall_rdata", i1_icb.icb_rsp_rdata, 32'hCAFE_F00D);
        check("stall_err", i1_icb.icb_rsp_err, 1);
        check("stall_i0_none", i0_icb.icb_rsp_valid, 0);
        cycle();
        o_icb.icb_rsp_valid = 0;
        #1; check("stall_drained", arbt_active, 0);

        // Asynchronous reset with two outstanding ids.
        do_reset();
        i0_icb.icb_cmd_valid = 1; o_icb.icb_cmd_ready = 1;
        cycle();
        cycle();
        i0_icb.icb_cmd_valid = 0;
        #1; check("pre_rst_active", arbt_active, 1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_active", arbt_active, 0);
        o_icb.icb_rsp_valid = 1; i0_icb.icb_rsp_ready = 1;
        #1;
        check("rst_rsp_ready", o_icb.icb_rsp_ready, 0);
        check("rst_i0_rsp_valid", i0_icb.icb_rsp_valid, 0);
        i0_icb.icb_cmd_valid = 1; i1_icb.icb_cmd_valid = 1;
        #1;
        check("rst_ptr_i0_ready", i0_icb.icb_cmd_ready, 1);
        check("rst_ptr_i1_ready", i1_icb.icb_cmd_ready, 0);
        cycle();
        drive_idle();
        rst_n = 1'b1;
        cycle();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            rst_n = ($urandom_range(0, 399) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/n101_icb_rr_arbt.md
N101_ICB_RR_ARBT -- requirements
Module: n101_icb_rr_arbt

Interface
REQ-001 Parameter AW, default 32, address width.
REQ-002 Parameter DW, default 32, data width; DW/8 mask bits.
REQ-003 Parameter OUTS_NUM, default 2, maximum outstanding commands (legal range 1..4).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 iN_icb_cmd_valid / iN_icb_cmd_ready  input / output  1 each  command handshake for requester N, where N=0,1.
REQ-007 iN_icb_cmd_addr / read / wdata / wmask / lock  input  AW / 1 / DW / DW/8 / 1  command payload for requester N.
REQ-008 iN_icb_rsp_valid / iN_icb_rsp_ready  output / input  1 each  response handshake for requester N.
REQ-009 iN_icb_rsp_err / iN_icb_rsp_rdata  output  1 / DW  response payload for requester N.
REQ-010 o_icb_cmd_valid / o_icb_cmd_ready  output / input  1 each  shared command port handshake.
REQ-011 o_icb_cmd_addr / read / wdata / wmask / lock  output  AW / 1 / DW / DW/8 / 1  shared command payload.
REQ-012 o_icb_rsp_valid, o_icb_rsp_err, o_icb_rsp_rdata  input  1 / 1 / DW  shared response.
REQ-013 o_icb_rsp_ready  output  1  shared response ready.
REQ-014 arbt_active  output  1  high when any cmd_valid is asserted or outstanding count is nonzero.

Function
REQ-015 State: round-robin pointer ptr (1 bit), lock_own (1 bit), lock_id (1 bit), and an ID FIFO of OUTS_NUM entries with count, rd/wr pointers.
REQ-016 Grant selection is combinational: if lock_own=1, sel=lock_id; else if exactly one valid, sel=that requester; else if both valid, sel=ptr.
REQ-017 full = (count==OUTS_NUM), evaluated on the registered count; a same-cycle pop does not release the full condition.
REQ-018 o_icb_cmd_valid = iSel_cmd_valid & ~full; the payload is iSel's payload, and is all-zero when no requester is valid.
REQ-019 iN_icb_cmd_ready = (sel==N) & o_icb_cmd_ready & ~full; the non-selected requester's ready is 0.
REQ-020 On cmd handshake: push sel into the FIFO, count+1, and ptr <= ~sel.
REQ-021 Lock: a handshake with lock=1 sets lock_own=1 and lock_id=sel; a handshake from lock_id with lock=0 clears lock_own. While lock_own=1, the other requester is never granted, regardless of ptr.
REQ-022 Responses are in-order and routed by the FIFO head id: i<head>_rsp_valid = o_icb_rsp_valid & ~empty; the other requester's rsp_valid is 0; err and rdata are broadcast to both.
REQ-023 o_icb_rsp_ready = i<head>_rsp_ready & ~empty; when empty, o_icb_rsp_ready=0 (a zero-cycle or unsolicited response stalls and is never routed).
REQ-024 On rsp handshake: pop, count-1; simultaneous push and pop leaves count unchanged, and both pointers advance modulo OUTS_NUM.
REQ-025 Latency: 0 cycles from cmd input to o_icb_cmd (pure pass-through mux); 0 cycles on the response path.
REQ-026 Count width is clog2(OUTS_NUM+1); count never exceeds OUTS_NUM and never underflows.

Reset
REQ-027 While rst_n=0: ptr=0 (i0 first priority), lock_own=0, lock_id=0, count=0, FIFO pointers=0.
REQ-028 Reset asserted mid-transaction discards all outstanding ids; afterwards all rsp_valid outputs and o_icb_rsp_ready are 0 until a new cmd is accepted.
REQ-029 Output values during reset follow REQ-018 to REQ-023 with empty=1 and full=0.

Verification
REQ-030 Both requesters valid continuously, o_icb_cmd_ready=1, responses returned 1 cycle after each cmd -> grants alternate i0,i1,i0,i1; each response reaches the issuing requester.
REQ-031 OUTS_NUM=2, two cmds accepted, no responses -> third cmd sees o_icb_cmd_valid=0 and both readies 0; a pop in the same cycle still blocks that cycle; the next cycle accepts.
REQ-032 i0 sends lock=1, then lock=1, then lock=0, while i1 is continuously valid -> i1 is granted only after the lock=0 beat from i0 handshakes.
REQ-033 o_icb_rsp_valid=1 with count=0 -> o_icb_rsp_ready=0, i0/i1 rsp_valid=0, no state change.
REQ-034 i1_rsp_ready=0 for 3 cycles with the head id=1 -> o_icb_rsp_ready=0 for those cycles; the response is delivered intact on the 4th cycle; i0 receives nothing.
REQ-035 rst_n pulsed low with count=2 -> count=0, ptr=0, lock_own=0, arbt_active=0 immediately (asynchronously).
